// File: rtl/mem_bist_if.sv
// Single-port memory bus between the BIST master and the memory.
//   r_w   : 1 = write, 0 = read (master -> mem)
//   addr  : word address         (master -> mem)
//   wr_d  : write data           (master -> mem)
//   rd_d  : read data, valid the cycle after mem samples a read (mem -> master)
interface mem_bist_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              r_w;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wr_d;
   logic [DATA_W-1:0] rd_d;

   modport master (output r_w, addr, wr_d, input rd_d);
   modport slave  (input r_w, addr, wr_d, output rd_d);
endinterface

// File: rtl/mem_bist_master.sv
// Built-in self-test master: runs a 4-phase march over the whole memory
// (write P, read/check P, write ~P, read/check ~P) and reports the result.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : request a run (sampled only in IDLE)
//   pattern    : base pattern, captured when start is accepted
//   bus        : memory bus (master modport)
//   busy       : run in progress
//   done       : one-cycle pulse at end of run
//   pass       : last run had no mismatches (held until next start)
//   err_cnt    : saturating mismatch count of last run
//   err_addr   : address of first mismatch of last run (0 if none)
module mem_bist_master #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] pattern,
   mem_bist_if.master        bus,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [ADDR_W-1:0] err_addr
);
   typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DRAIN, DONE} state_t;

   state_t                   state;
   logic [DATA_W-1:0]        pat;
   logic                     drain_cnt;
   // Stage 0 is loaded when a read address is presented, stage 1 one edge
   // later; rd_d is then compared against stage 1 on the following edge.
   logic [1:0]               vld_pipe;
   logic [1:0][DATA_W-1:0]   exp_pipe;
   logic [1:0][ADDR_W-1:0]   adr_pipe;

   logic                     last;
   logic [ADDR_W-1:0]        addr_inc;
   logic                     mismatch;

   assign last     = &bus.addr;
   assign addr_inc = bus.addr + ADDR_W'(1);
   assign mismatch = vld_pipe[1] && (bus.rd_d != exp_pipe[1]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         bus.r_w   <= 1'b0;
         bus.addr  <= '0;
         bus.wr_d  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_cnt   <= '0;
         err_addr  <= '0;
         pat       <= '0;
         drain_cnt <= 1'b0;
         vld_pipe  <= '0;
         exp_pipe  <= '0;
         adr_pipe  <= '0;
      end else begin
         done        <= 1'b0;
         vld_pipe    <= {vld_pipe[0], 1'b0};
         exp_pipe[1] <= exp_pipe[0];
         adr_pipe[1] <= adr_pipe[0];

         // Counter only ever grows within a run, so zero means first mismatch.
         if (mismatch) begin
            if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
            if (err_cnt == '0) err_addr <= adr_pipe[1];
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state    <= WR0;
                  pat      <= pattern;
                  bus.r_w  <= 1'b1;
                  bus.addr <= '0;
                  bus.wr_d <= pattern;
                  busy     <= 1'b1;
                  pass     <= 1'b0;
                  err_cnt  <= '0;
                  err_addr <= '0;
               end
            end
            WR0: begin
               bus.addr <= last ? '0 : addr_inc;
               if (last) begin
                  state       <= RD0;
                  bus.r_w     <= 1'b0;
                  bus.wr_d    <= '0;
                  vld_pipe[0] <= 1'b1;
                  exp_pipe[0] <= pat;
                  adr_pipe[0] <= '0;
               end
            end
            RD0: begin
               bus.addr <= last ? '0 : addr_inc;
               if (last) begin
                  state    <= WR1;
                  bus.r_w  <= 1'b1;
                  bus.wr_d <= ~pat;
               end else begin
                  vld_pipe[0] <= 1'b1;
                  exp_pipe[0] <= pat;
                  adr_pipe[0] <= addr_inc;
               end
            end
            WR1: begin
               bus.addr <= last ? '0 : addr_inc;
               if (last) begin
                  state       <= RD1;
                  bus.r_w     <= 1'b0;
                  bus.wr_d    <= '0;
                  vld_pipe[0] <= 1'b1;
                  exp_pipe[0] <= ~pat;
                  adr_pipe[0] <= '0;
               end
            end
            RD1: begin
               bus.addr <= last ? '0 : addr_inc;
               if (last) begin
                  state     <= DRAIN;
                  drain_cnt <= 1'b0;
               end else begin
                  vld_pipe[0] <= 1'b1;
                  exp_pipe[0] <= ~pat;
                  adr_pipe[0] <= addr_inc;
               end
            end
            DRAIN: begin
               // Two idle read cycles let the last two RD1 compares retire
               // before pass is decided.
               if (!drain_cnt) begin
                  drain_cnt <= 1'b1;
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  pass  <= (err_cnt == '0);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_bist_master.sv
module tb_mem_bist_master;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start0, start1;
   logic [7:0] pat0, pat1;
   logic       busy0, done0, pass0, busy1, done1, pass1;
   logic [7:0] ecnt0;
   logic [3:0] ecnt1;
   logic [3:0] eaddr0, eaddr1;

   mem_bist_if #(.ADDR_W(4), .DATA_W(8)) bus0();
   mem_bist_if #(.ADDR_W(4), .DATA_W(8)) bus1();

   mem_bist_master #(.ADDR_W(4), .DATA_W(8), .ERR_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start0), .pattern(pat0), .bus(bus0),
      .busy(busy0), .done(done0), .pass(pass0), .err_cnt(ecnt0), .err_addr(eaddr0));

   mem_bist_master #(.ADDR_W(4), .DATA_W(8), .ERR_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start1), .pattern(pat1), .bus(bus1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(ecnt1), .err_addr(eaddr1));

   int checks = 0;
   int errors = 0;

   // Optional stuck-at fault on one bit of one word (memory for dut).
   logic       stuck_en;
   logic [3:0] stuck_a;
   int         stuck_b;
   logic       stuck_v;
   logic [7:0] mem0 [DEPTH];

   function automatic logic [7:0] stuck_rd(input logic [7:0] v, input logic [3:0] a);
      logic [7:0] r;
      r = v;
      if (stuck_en && a == stuck_a) r[stuck_b] = stuck_v;
      return r;
   endfunction

   always @(posedge clk) begin
      if (bus0.r_w) mem0[bus0.addr] <= bus0.wr_d;
      else          bus0.rd_d       <= stuck_rd(mem0[bus0.addr], bus0.addr);
   end

   // Memory for dut4: ignores writes, always reads zero.
   always @(posedge clk) bus1.rd_d <= 8'h00;

   // Reference: play the march over an array and count mismatches.
   function automatic void model_run(input int which, input logic [7:0] p,
                                     output int ecnt, output int eaddr, output bit epass);
      logic [7:0] m [DEPTH];
      logic [7:0] rd, ex;
      int n;
      int sat;
      n = 0;
      sat = (which == 1) ? 15 : 255;
      eaddr = 0;
      for (int ph = 0; ph < 4; ph++)
         for (int a = 0; a < DEPTH; a++) begin
            if (ph == 0)      m[a] = p;
            else if (ph == 2) m[a] = ~p;
            else begin
               ex = (ph == 1) ? p : ~p;
               rd = (which == 1) ? 8'h00 : stuck_rd(m[a], 4'(a));
               if (rd != ex) begin
                  if (n == 0) eaddr = a;
                  n++;
               end
            end
         end
      ecnt  = (n > sat) ? sat : n;
      epass = (n == 0);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic get_obs(input int which, output logic rw, output logic [3:0] ad,
                          output logic [7:0] wd, output logic bz, output logic dn,
                          output logic ps, output logic [7:0] ec, output logic [3:0] ea);
      if (which == 0) begin
         rw = bus0.r_w; ad = bus0.addr; wd = bus0.wr_d;
         bz = busy0; dn = done0; ps = pass0; ec = ecnt0; ea = eaddr0;
      end else begin
         rw = bus1.r_w; ad = bus1.addr; wd = bus1.wr_d;
         bz = busy1; dn = done1; ps = pass1; ec = {4'b0, ecnt1}; ea = eaddr1;
      end
   endtask

   // One full run: starts on the next edge (e0), checks every bus cycle,
   // busy/done timing and the result. Optional extra start pulse at cycle rc.
   task automatic run_check(input string name, input int which, input logic [7:0] p, input int rc);
      int exp_cnt, exp_addr;
      bit exp_pass;
      logic rw, bz, dn, ps;
      logic [3:0] ad, ea;
      logic [7:0] wd, ec;
      logic erw;
      logic [3:0] ead;
      logic [7:0] ewd;
      int ph;
      model_run(which, p, exp_cnt, exp_addr, exp_pass);
      if (which == 0) begin start0 = 1'b1; pat0 = p; end
      else            begin start1 = 1'b1; pat1 = p; end
      tick();
      start0 = 1'b0; start1 = 1'b0;
      for (int c = 0; c <= 4*DEPTH+4; c++) begin
         get_obs(which, rw, ad, wd, bz, dn, ps, ec, ea);
         if (c < 4*DEPTH) begin
            ph  = c / DEPTH;
            erw = (ph % 2 == 0);
            ead = 4'(c % DEPTH);
            ewd = (ph == 0) ? p : (ph == 2) ? ~p : 8'h00;
         end else begin
            erw = 1'b0; ead = 4'h0; ewd = 8'h00;
         end
         checks++;
         if ({rw, ad, wd} !== {erw, ead, ewd}) begin
            errors++;
            $display("FAIL %s bus c=%0d: got r_w=%b addr=%0d wr_d=%h, want r_w=%b addr=%0d wr_d=%h",
                     name, c, rw, ad, wd, erw, ead, ewd);
         end
         checks++;
         if (bz !== (c < 4*DEPTH+2) || dn !== (c == 4*DEPTH+2)) begin
            errors++;
            $display("FAIL %s busy/done c=%0d: got %b/%b, want %b/%b",
                     name, c, bz, dn, c < 4*DEPTH+2, c == 4*DEPTH+2);
         end
         if (c >= 4*DEPTH+2) begin
            checks++;
            if (ps !== exp_pass || ec !== 8'(exp_cnt) || ea !== 4'(exp_addr)) begin
               errors++;
               $display("FAIL %s result c=%0d: got pass=%b cnt=%0d addr=%0d, want pass=%b cnt=%0d addr=%0d",
                        name, c, ps, ec, ea, exp_pass, exp_cnt, exp_addr);
            end
         end
         if (which == 0) start0 = (c == rc);
         else            start1 = (c == rc);
         tick();
      end
      start0 = 1'b0; start1 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({bus0.r_w, bus0.addr, bus0.wr_d, busy0, done0, pass0, ecnt0, eaddr0} !== '0 ||
             {bus1.r_w, bus1.addr, bus1.wr_d, busy1, done1, pass1, ecnt1, eaddr1} !== '0) begin
            errors++;
            $display("FAIL reset k=%0d: got r_w=%b addr=%h wr_d=%h busy=%b done=%b pass=%b cnt=%h eaddr=%h, want all 0",
                     k, bus0.r_w, bus0.addr, bus0.wr_d, busy0, done0, pass0, ecnt0, eaddr0);
         end
         rst_n = 1'b1;
         tick();
      end
   endtask

   task automatic test_clean();
      stuck_en = 1'b0;
      run_check("clean", 0, 8'hA5, -1);
   endtask

   task automatic test_stuck();
      stuck_en = 1'b1; stuck_a = 4'd7; stuck_b = 0; stuck_v = 1'b0;
      run_check("stuck7", 0, 8'hA5, -1);
      stuck_en = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++) begin
         stuck_en = 1'($urandom_range(0, 1));
         stuck_a  = 4'($urandom_range(0, 15));
         stuck_b  = $urandom_range(0, 7);
         stuck_v  = 1'($urandom_range(0, 1));
         run_check("random", 0, 8'($urandom), -1);
      end
      stuck_en = 1'b0;
   endtask

   task automatic test_restart();
      run_check("restart", 0, 8'($urandom), 20);
   endtask

   task automatic test_reset_midrun();
      start0 = 1'b1; pat0 = 8'h3C;
      tick();
      start0 = 1'b0;
      repeat (25) tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if (bus0.r_w !== 1'b0 || bus0.addr !== 4'h0 || busy0 !== 1'b0 || done0 !== 1'b0 || ecnt0 !== 8'h00) begin
         errors++;
         $display("FAIL reset_midrun: got r_w=%b addr=%0d busy=%b done=%b cnt=%0d, want 0/0/0/0/0",
                  bus0.r_w, bus0.addr, busy0, done0, ecnt0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 80; k++) begin
         tick();
         checks++;
         if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun idle k=%0d: got done=%b busy=%b, want 0/0", k, done0, busy0);
         end
      end
      run_check("after_reset", 0, 8'($urandom), -1);
   endtask

   task automatic test_saturate();
      run_check("saturate", 1, 8'hFF, -1);
      run_check("sat_rand", 1, 8'($urandom), -1);
   endtask

   task automatic test_back_to_back();
      logic [7:0] p;
      int waited;
      p = 8'($urandom);
      start0 = 1'b1; pat0 = p;
      tick();
      for (int c = 0; c < 4*DEPTH+4; c++) tick();
      // c = 4*DEPTH+4: second run already accepted
      checks++;
      if (busy0 !== 1'b1 || bus0.r_w !== 1'b1 || bus0.addr !== 4'h0 || bus0.wr_d !== p) begin
         errors++;
         $display("FAIL back_to_back restart: got busy=%b r_w=%b addr=%0d wr_d=%h, want 1/1/0/%h",
                  busy0, bus0.r_w, bus0.addr, bus0.wr_d, p);
      end
      start0 = 1'b0;
      waited = 0;
      while (done0 !== 1'b1 && waited < 200) begin
         tick();
         waited++;
      end
      checks++;
      if (done0 !== 1'b1 || pass0 !== 1'b1) begin
         errors++;
         $display("FAIL back_to_back second run: got done=%b pass=%b after %0d cycles, want 1/1",
                  done0, pass0, waited);
      end
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      start0 = 1'b0; start1 = 1'b0;
      pat0 = 8'h00; pat1 = 8'h00;
      stuck_en = 1'b0; stuck_a = 4'h0; stuck_b = 0; stuck_v = 1'b0;
      test_reset();
      test_clean();
      test_stuck();
      test_random();
      test_restart();
      test_reset_midrun();
      test_saturate();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
